// File: rtl/ram_pixel_fetcher.sv
// Sequential word fetcher: walks word addresses for a frame and buffers each word in a show-ahead FIFO.
// Optional per-word watchdog enabled by defining FETCH_WATCHDOG_EN.
module ram_pixel_fetcher #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [26:0] base_addr,
    input  logic [23:0] frame_words,
    output logic [26:0] read_address,
    input  logic [15:0] read_data_out,
    input  logic        read_data_valid,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic        fetch_timeout
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        STALL
    } state_t;

    state_t         state, state_next;
    logic [23:0]    frame_len;
    logic [23:0]    word_cnt;

    logic [15:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_after;

    logic           issue;
    logic [26:0]    issue_addr;
    logic           push;
    logic           pop;
    logic           last;
    logic           load;

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]  wd_cnt;
    logic           timeout_hit;
`endif

    assign pix_valid   = (fifo_count != '0);
    assign pix_data    = mem[rd_ptr];
    assign pop         = pix_valid & pix_ready;
    assign count_after = fifo_count + CW'(1) - CW'(pop);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_addr = read_address;
        push       = 1'b0;
        last       = 1'b0;
        load       = 1'b0;
`ifdef FETCH_WATCHDOG_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    issue      = 1'b1;
                    issue_addr = base_addr;
                end
            end
            WAIT_LOW: begin
                if (!read_data_valid) state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (read_data_valid) begin
                    push = 1'b1;
                    if (word_cnt + 24'd1 == frame_len) begin
                        last       = 1'b1;
                        state_next = IDLE;
                    end else if (count_after < DEPTH_C) begin
                        issue      = 1'b1;
                        issue_addr = read_address + 27'd1;
                    end else begin
                        state_next = STALL;
                    end
                end
            end
            STALL: begin
                if (fifo_count < DEPTH_C) begin
                    issue      = 1'b1;
                    issue_addr = read_address + 27'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // An unchanged address never drops valid, so skip the low phase.
        if (issue) state_next = (issue_addr != read_address) ? WAIT_LOW : WAIT_HIGH;

`ifdef FETCH_WATCHDOG_EN
        if ((state == WAIT_LOW || state == WAIT_HIGH) && !push &&
            wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_next  = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            read_address <= '0;
            frame_len    <= 24'd1;
            word_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= push & last;
            if (issue) read_address <= issue_addr;
            if (load) begin
                frame_len <= (frame_words == '0) ? 24'd1 : frame_words;
                word_cnt  <= '0;
            end else if (push) begin
                word_cnt <= word_cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= read_data_out;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt        <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            if (issue)
                wd_cnt <= '0;
            else if (state == WAIT_LOW || state == WAIT_HIGH)
                wd_cnt <= wd_cnt + WW'(1);
            if (load)
                fetch_timeout <= 1'b0;
            else if (timeout_hit)
                fetch_timeout <= 1'b1;
        end
    end
`else
    assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ram_pixel_fetcher.sv
// Directed self-checking bench for ram_pixel_fetcher with a behavioural DDR word-reader model.
module tb_ram_pixel_fetcher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [26:0] base_addr;
    logic [23:0] frame_words;
    logic [26:0] read_address;
    logic [15:0] read_data_out;
    logic        read_data_valid;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic        fetch_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    ram_pixel_fetcher #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .frame_words    (frame_words),
        .read_address   (read_address),
        .read_data_out  (read_data_out),
        .read_data_valid(read_data_valid),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .busy           (busy),
        .done           (done),
        .fetch_timeout  (fetch_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [26:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Reader model: on an address change keep the old word for stale_cfg cycles,
    // drop valid for low_cfg cycles, then present the new word.
    logic [26:0] rd_seen   = '0;
    int          stale_cfg = 0;
    int          low_cfg   = 3;
    int          stale_left = 0;
    int          low_left   = 0;
    logic        hold_low  = 1'b0;

    initial begin
        read_data_valid = 1'b1;
        read_data_out   = word_of(27'd0);
    end

    always @(negedge clk) begin
        if (read_address !== rd_seen) begin
            rd_seen    = read_address;
            stale_left = stale_cfg;
            low_left   = low_cfg;
        end
        if (stale_left > 0) begin
            stale_left--;
        end else if (low_left > 0 || hold_low) begin
            read_data_valid = 1'b0;
            if (low_left > 0) low_left--;
        end else begin
            read_data_valid = 1'b1;
            read_data_out   = word_of(rd_seen);
        end
    end

    logic [15:0] got[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) got.push_back(pix_data);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [26:0] b, input logic [23:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; frame_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < 300 && got.size() < n; i++) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got.size()), 32'(n));
    endtask

    task automatic compare_frame(input string tag, input logic [26:0] addrs[], input int n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size())
                check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(word_of(addrs[i])));
            else
                check($sformatf("%s_w%0d_missing", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [26:0] a[];
        int d0;

        reset_n = 1'b0; start = 1'b0; base_addr = '0; frame_words = '0; pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(read_address), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(fetch_timeout), 32'd0);
        reset_n = 1'b1;

        // Basic frame
        pix_ready = 1'b1; got.delete(); d0 = done_cnt;
        pulse_start(27'h100, 24'd8);
        check("basic_first_addr", 32'(read_address), 32'h100);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done("basic");
        wait_words("basic", 8);
        a = new[8];
        a = '{27'h100, 27'h101, 27'h102, 27'h103, 27'h104, 27'h105, 27'h106, 27'h107};
        compare_frame("basic", a, 8);
        check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("basic_last_addr", 32'(read_address), 32'h107);
        check("basic_empty", 32'(pix_valid), 32'd0);

        // Backpressure
        pix_ready = 1'b0; got.delete();
        pulse_start(27'h300, 24'd10);
        repeat (60) @(posedge clk);
        #1;
        check("bp_fifo_count", 32'(dut.fifo_count), 32'd4);
        check("bp_addr_held", 32'(read_address), 32'h303);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_head", 32'(pix_data), 32'(16'h300 ^ 16'hA5C3));
        pulse_start(27'h555, 24'd2);
        check("bp_start_ignored", 32'(read_address), 32'h303);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_done("bp");
        wait_words("bp", 10);
        a = new[10];
        a = '{27'h300, 27'h301, 27'h302, 27'h303, 27'h304,
              27'h305, 27'h306, 27'h307, 27'h308, 27'h309};
        compare_frame("bp", a, 10);

        // Stale valid after address change
        stale_cfg = 2; low_cfg = 2; got.delete();
        pulse_start(27'h400, 24'd5);
        wait_done("stale");
        wait_words("stale", 5);
        a = new[5];
        a = '{27'h400, 27'h401, 27'h402, 27'h403, 27'h404};
        compare_frame("stale", a, 5);
        stale_cfg = 0; low_cfg = 3;

        // Same address: park at 0x200, then refetch it
        got.delete();
        pulse_start(27'h1FE, 24'd3);
        wait_done("park");
        wait_words("park", 3);
        check("park_addr", 32'(read_address), 32'h200);
        got.delete();
        pulse_start(27'h200, 24'd1);
        check("same_addr", 32'(read_address), 32'h200);
        check("same_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("same_done_fast", 32'(done), 32'd1);
        wait_words("same", 1);
        a = new[1];
        a = '{27'h200};
        compare_frame("same", a, 1);
        got.delete(); d0 = done_cnt;
        pulse_start(27'h200, 24'd0);
        @(posedge clk); #1;
        check("zero_len_done", 32'(done), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("zero_len_words", 32'(got.size()), 32'd1);
        check("zero_len_pulses", 32'(done_cnt - d0), 32'd1);

        // Address wrap
        got.delete();
        pulse_start(27'h7FFFFFE, 24'd4);
        wait_done("wrap");
        wait_words("wrap", 4);
        a = new[4];
        a = '{27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h0000001};
        compare_frame("wrap", a, 4);
        check("wrap_last_addr", 32'(read_address), 32'h1);

        // Reader never reasserts valid
        hold_low = 1'b1; d0 = done_cnt;
        pulse_start(27'h600, 24'd2);
`ifdef FETCH_WATCHDOG_EN
        repeat (15) @(posedge clk);
        #1;
        check("wd_not_yet", 32'(fetch_timeout), 32'd0);
        @(posedge clk); #1;
        check("wd_timeout", 32'(fetch_timeout), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_no_done", 32'(done_cnt - d0), 32'd0);
        pulse_start(27'h600, 24'd2);
        check("wd_clear_on_start", 32'(fetch_timeout), 32'd0);
`else
        repeat (40) @(posedge clk);
        #1;
        check("hang_busy", 32'(busy), 32'd1);
        check("hang_timeout", 32'(fetch_timeout), 32'd0);
        check("hang_no_done", 32'(done_cnt - d0), 32'd0);
`endif

        // Asynchronous reset mid-frame
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_addr", 32'(read_address), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_timeout", 32'(fetch_timeout), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; hold_low = 1'b0;

        got.delete();
        pulse_start(27'h700, 24'd2);
        wait_done("post");
        wait_words("post", 2);
        a = new[2];
        a = '{27'h700, 27'h701};
        compare_frame("post", a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_pixel_fetcher.md
# ram_pixel_fetcher

Sequential word fetcher that sits directly downstream of the DDR3 16-bit word reader. It drives the reader's word address and captures each returned 16-bit word into a show-ahead FIFO, from which the display/consumer side pops pixels. One frame is a run of `frame_words` consecutive word addresses starting at `base_addr`. The reader's `read_data_valid` is used as a drop-then-rise handshake per address.

## Interface
- `FIFO_DEPTH`, 16: pixel FIFO depth in words; power of two, ≥ 4.
- `TIMEOUT_CYCLES`, 4096: watchdog limit per word; used only with the macro.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame; sampled only in IDLE.
- `base_addr` in 27: first word address; sampled with `start`.
- `frame_words` in 24: words per frame; sampled with `start`; 0 is treated as 1.
- `read_address` out 27: word address to the reader; registered.
- `read_data_out` in 16: word from the reader.
- `read_data_valid` in 1: reader output-valid.
- `pix_data` out 16: FIFO head word, show-ahead.
- `pix_valid` out 1: FIFO non-empty.
- `pix_ready` in 1: consumer pop; a pop occurs when `pix_valid & pix_ready`.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse after the last word of a frame is captured.
- `fetch_timeout` out 1: sticky watchdog error; constant 0 without the macro.

## Operation
- States: IDLE, WAIT_LOW, WAIT_HIGH, STALL.
- **Issuing an address:**
  - The registered address is loaded with `base_addr` (first word) or `read_address+1` (next word).
  - Address arithmetic is mod 2^27; wrap from 27'h7FFFFFF to 0 is legal.
  - If the new address differs from the currently driven address, go to WAIT_LOW.
  - If it is equal, the reader will not deassert valid, so go straight to WAIT_HIGH.
- **IDLE:** on `start`, latch `base_addr` and `frame_words` (0 becomes 1), clear the word counter, clear `fetch_timeout`, and issue `base_addr`.
- **WAIT_LOW:** remain until `read_data_valid == 0` is sampled, then go to WAIT_HIGH. Valid still high from the previous address is never captured.
- **WAIT_HIGH:** on `read_data_valid == 1`, push `read_data_out` into the FIFO and increment the word counter. Then:
  - Last word of the frame: go to IDLE and pulse `done`.
  - Otherwise, FIFO count after push and pop < `FIFO_DEPTH`: issue the next address on the same edge.
  - Otherwise: go to STALL.
- **STALL:** issue the next address on the first cycle the FIFO count is < `FIFO_DEPTH`.
- At most one word is outstanding, so a push never occurs while the FIFO is full.
- **FIFO:**
  - Push and pop in the same cycle leave the count unchanged.
  - A pop while empty is ignored.
  - Push data appears on `pix_data` the cycle after the push edge.
- `start` while busy is ignored. `read_address` holds its last value in IDLE.
- Reset mid-frame: asynchronous return to reset values; FIFO contents are discarded.

## Timing
- Reset values:
  - `read_address`=0, `pix_data`=0, `pix_valid`=0, `busy`=0, `done`=0, `fetch_timeout`=0.
  - FIFO empty, state IDLE.
- `start` at edge k: `read_address`=`base_addr` and `busy`=1 after edge k.
- Capture at edge m (WAIT_HIGH with valid high):
  - `pix_valid`=1 after edge m.
  - Next address driven after edge m, if there is space.
  - `done`=1 for the single cycle after the final capture edge; `busy`=0 in that same cycle.
- Per-word latency equals the reader's deassert-to-reassert time plus 1 cycle. The fetcher adds no other wait states.
- All outputs are registered, except `pix_data` and `pix_valid`, which come from FIFO registers.

## Configuration
- `FETCH_WATCHDOG_EN` defined:
  - A counter runs in WAIT_LOW and WAIT_HIGH and clears on every issue.
  - On reaching `TIMEOUT_CYCLES`, set `fetch_timeout`=1 and go to IDLE without pulsing `done`. FIFO contents are kept.
  - `fetch_timeout` clears on the next accepted `start`.
- `FETCH_WATCHDOG_EN` undefined: no counter, `fetch_timeout` tied to 0, and the fetcher waits indefinitely.

## Test plan
- **Basic frame:** reader model deasserts valid for 3 cycles per address change; `start`, `base_addr`=0x100, `frame_words`=8 → addresses 0x100–0x107 driven in order, FIFO receives 8 correct words, one `done` pulse, `busy` then low.
- **Backpressure:** `FIFO_DEPTH`=4, `pix_ready`=0, `frame_words`=10 → exactly 4 words captured, state STALL, address held at 0x103. Raising `pix_ready` → all 10 words delivered in order.
- **Stale valid:** reader keeps valid high 2 cycles after an address change before dropping → the old word is not captured; each captured word matches its address.
- **Same address:** `read_address` idle at 0x200; start with `base_addr`=0x200, `frame_words`=1 → capture without valid dropping, `done` within 2 cycles.
- **Wrap:** `base_addr`=27'h7FFFFFE, `frame_words`=4 → addresses 7FFFFFE, 7FFFFFF, 0, 1.
- **Watchdog (macro on, `TIMEOUT_CYCLES`=16):** reader never reasserts valid → `fetch_timeout`=1 after 16 cycles, `busy`=0, no `done`. Async `reset_n` low mid-frame → all outputs at reset values immediately.
